// File: rtl/mux_nx1_reg_pkg.sv
// mux_nx1_reg shared package: mode encodings and the
// round-robin pointer advance.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int next_rr_ptr(
    input int g,
    input int nch
  );
    return (g == nch - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_reg_if.sv
// Stream bundle for mux_nx1_reg: N producer channels in,
// one registered stream out. MUX_PARITY_EN adds out_par.
interface mux_nx1_reg_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int SEL_W = $clog2(NCH);

  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;
`ifdef MUX_PARITY_EN
  logic             out_par;
`endif

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid
`ifdef MUX_PARITY_EN
    ,
    input  out_par
`endif
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid
`ifdef MUX_PARITY_EN
    ,
    output out_par
`endif
  );

endinterface

// File: rtl/mux_nx1_reg_rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or
// above ptr, wrapping NCH-1 -> 0.
module rr_arbiter_n #(
  parameter  int NCH   = 4,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int j;

  // Scan farthest offset first so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[j[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 stream mux, fixed-select or round-robin.
// Build with MUX_PARITY_EN to add the out_par output.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input logic          clk,
  input logic          rst_n,
  mux_nx1_reg_if.slave bus
);

  localparam int SEL_W = $clog2(NCH);

  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] r_ch;
  logic [W-1:0]     r_data;
  logic             r_valid;

  logic [SEL_W-1:0] w_arb_idx;
  logic             w_arb_vld;
  logic             w_fix_vld;
  logic [SEL_W-1:0] w_g;
  logic             w_gv;
  logic             w_load;
  logic             w_xfer;
  logic [W-1:0]     w_data;
  logic [NCH-1:0]   w_ready;

  rr_arbiter_n #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_vld (w_arb_vld)
  );

  // rst_n gates load so no channel sees ready during reset.
  assign w_load = rst_n && (!r_valid || bus.out_ready);

  always_comb begin
    w_fix_vld = 1'b0;
    if (int'(bus.sel) < NCH)
      w_fix_vld = bus.in_valid[bus.sel];
  end

  always_comb begin
    w_g  = bus.sel;
    w_gv = w_fix_vld;
    if (bus.mode == MODE_RR) begin
      w_g  = w_arb_idx;
      w_gv = w_arb_vld;
    end
  end

  assign w_xfer = w_load && w_gv;
  assign w_data = bus.in_data[w_g*W +: W];

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ch     <= '0;
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_ch    <= w_g;
      if (bus.mode == MODE_RR)
        r_rr_ptr <= SEL_W'(next_rr_ptr(int'(w_g), NCH));
    end else if (w_load && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_par <= 1'b0;
    else if (w_xfer) r_par <= ^w_data;
  end

  assign bus.out_par = r_par;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: directed table,
// reset/parity sequences and a randomized model check.
module tb_mux_nx1_reg;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nx1_reg_if #(.NCH(NCH), .W(W)) bus ();

  mux_nx1_reg #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
  } vec_t;

  vec_t tv[20];

  // Reference model state
  logic       m_vld;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;

  task automatic drive(
    input logic        mode,
    input logic [1:0]  sel,
    input logic [3:0]  iv,
    input logic [31:0] dat,
    input logic        ordy
  );
    bus.mode      = mode;
    bus.sel       = sel;
    bus.in_valid  = iv;
    bus.in_data   = dat;
    bus.out_ready = ordy;
  endtask

  // One cycle against the model; inputs already driven.
  task automatic step_model(input string tag);
    int   g;
    logic gv;
    logic [3:0] er;
    g  = 0;
    gv = 1'b0;
    if (bus.mode == 1'b0) begin
      g  = int'(bus.sel);
      gv = bus.in_valid[g];
    end else begin
      for (int off = NCH - 1; off >= 0; off--) begin
        if (bus.in_valid[(m_ptr + off) % NCH]) begin
          g  = (m_ptr + off) % NCH;
          gv = 1'b1;
        end
      end
    end
    er = 4'b0;
    if ((!m_vld || bus.out_ready) && gv) er[g] = 1'b1;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(er));
    @(posedge clk);
    #1;
    if (er != 4'b0) begin
      m_vld  = 1'b1;
      m_data = bus.in_data[g*W +: W];
      m_ch   = 2'(g);
      if (bus.mode) m_ptr = (g + 1) % NCH;
    end else if (bus.out_ready) begin
      m_vld = 1'b0;
    end
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(m_vld));
    if (m_vld) begin
      chk({tag, ".data"}, 64'(bus.out_data), 64'(m_data));
      chk({tag, ".ch"}, 64'(bus.out_ch), 64'(m_ch));
`ifdef MUX_PARITY_EN
      chk({tag, ".par"}, 64'(bus.out_par), 64'(^m_data));
`endif
    end
  endtask

  initial begin
    tv[0]  = '{0, 2, 4'b0110, 32'h44A52211, 1,
               4'b0100, 1, 8'hA5, 2};
    tv[1]  = '{0, 1, 4'b0010, 32'h00003C00, 1,
               4'b0010, 1, 8'h3C, 1};
    tv[2]  = '{0, 1, 4'b1010, 32'h77003C00, 0,
               4'b0000, 1, 8'h3C, 1};
    tv[3]  = '{0, 3, 4'b1010, 32'h77003C00, 0,
               4'b0000, 1, 8'h3C, 1};
    tv[4]  = '{0, 3, 4'b1010, 32'h77003C00, 0,
               4'b0000, 1, 8'h3C, 1};
    tv[5]  = '{0, 3, 4'b1010, 32'h77003C00, 1,
               4'b1000, 1, 8'h77, 3};
    tv[6]  = '{0, 3, 4'b0000, 32'h0, 1,
               4'b0000, 0, 8'h00, 0};
    tv[7]  = '{0, 3, 4'b0000, 32'h0, 0,
               4'b0000, 0, 8'h00, 0};
    tv[8]  = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b0001, 1, 8'hA0, 0};
    tv[9]  = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b0010, 1, 8'hB1, 1};
    tv[10] = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b0100, 1, 8'hC2, 2};
    tv[11] = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b1000, 1, 8'hD3, 3};
    tv[12] = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b0001, 1, 8'hA0, 0};
    tv[13] = '{1, 0, 4'b1111, 32'hD3C2B1A0, 1,
               4'b0010, 1, 8'hB1, 1};
    tv[14] = '{1, 0, 4'b0001, 32'hD3C2B1A0, 1,
               4'b0001, 1, 8'hA0, 0};
    tv[15] = '{1, 0, 4'b1001, 32'hD3C2B1A0, 1,
               4'b1000, 1, 8'hD3, 3};
    tv[16] = '{1, 0, 4'b1001, 32'hD3C2B1A0, 1,
               4'b0001, 1, 8'hA0, 0};
    tv[17] = '{1, 0, 4'b1001, 32'hD3C2B1A0, 1,
               4'b1000, 1, 8'hD3, 3};
    tv[18] = '{0, 0, 4'b1001, 32'hD3C2B1A0, 1,
               4'b0001, 1, 8'hA0, 0};
    tv[19] = '{1, 0, 4'b1110, 32'hD3C2B1A0, 1,
               4'b0010, 1, 8'hB1, 1};

    rst_n = 1'b0;
    drive(1, 0, 4'b1111, 32'hFFFFFFFF, 1);
    #1;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.data", 64'(bus.out_data), 64'd0);
    chk("rst.ch", 64'(bus.out_ch), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].mode, tv[i].sel, tv[i].iv,
            tv[i].dat, tv[i].ordy);
      #1;
      chk($sformatf("tv%0d.in_ready", i),
          64'(bus.in_ready), 64'(tv[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d.valid", i),
          64'(bus.out_valid), 64'(tv[i].e_vld));
      if (tv[i].e_vld) begin
        chk($sformatf("tv%0d.data", i),
            64'(bus.out_data), 64'(tv[i].e_data));
        chk($sformatf("tv%0d.ch", i),
            64'(bus.out_ch), 64'(tv[i].e_ch));
`ifdef MUX_PARITY_EN
        chk($sformatf("tv%0d.par", i),
            64'(bus.out_par), 64'(^tv[i].e_data));
`endif
      end
    end

    // Asynchronous reset while a word is held
    drive(1, 0, 4'b1111, 32'hD3C2B1A0, 0);
    #3;
    chk("midrst.pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.data", 64'(bus.out_data), 64'd0);
    chk("midrst.ch", 64'(bus.out_ch), 64'd0);
    chk("midrst.in_ready", 64'(bus.in_ready), 64'd0);
`ifdef MUX_PARITY_EN
    chk("midrst.par", 64'(bus.out_par), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("midrst.hold_rdy", 64'(bus.in_ready), 64'd0);
    rst_n  = 1'b1;
    m_vld  = 1'b0;
    m_data = '0;
    m_ch   = '0;
    m_ptr  = 0;

`ifdef MUX_PARITY_EN
    drive(0, 0, 4'b0001, 32'h00000007, 1);
    #1;
    step_model("par07");
    chk("par07.out_par", 64'(bus.out_par), 64'd1);
    drive(0, 0, 4'b0001, 32'h00000003, 1);
    #1;
    step_model("par03");
    chk("par03.out_par", 64'(bus.out_par), 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            $urandom,
            ($urandom_range(0, 9) < 7));
      #1;
      step_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
